id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus operand-forwarding mux for the 16-bit pipeline; sits directly upstream of the ALU.
//  Latches decoded operands, ALU control and writeback tags each cycle.
//  Resolves RAW hazards by bypassing EX/MEM and MEM/WB results into the ALU A/B inputs.
//  Supports stall (hold), flush (bubble) and a sticky HALT state.
// PARAMETERS
//  DW    16  datapath width (A, B, forwarded data)
//  RW     3  register-specifier width (8 GPRs; R0 is a normal register, never hardwired)
// PORTS
//  clk           in   1   system clock, all state updates on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  stall         in   1   hold all latched state this cycle
//  flush         in   1   replace the latched instruction with a bubble
//  id_valid      in   1   decode stage presents a real instruction
//  id_A, id_B    in   DW  register-file / immediate operands from decode
//  id_rs, id_rt  in   RW  source specifiers for id_A / id_B
//  id_rs_used    in   1   id_A comes from the register file (forwarding-eligible)
//  id_rt_used    in   1   id_B comes from the register file (forwarding-eligible)
//  id_alu_ctrl   in   13  {Cin,Op[2:0],invA,invB,sign,ex_BTR,ex_SLBI,comp_cont[1:0],comp,pass}, MSB first
//  id_wr_reg     in   RW  destination register
//  id_wr_en      in   1   instruction writes the register file
//  id_halt       in   1   instruction is HALT
//  exm_wr_en/exm_wr_reg/exm_data  in 1/RW/DW  EX/MEM producer
//  mwb_wr_en/mwb_wr_reg/mwb_data  in 1/RW/DW  MEM/WB producer
//  A, B          out  DW  forwarded ALU operands
//  Cin, Op, invA, invB, sign, ex_BTR, ex_SLBI, comp_cont, comp, pass  out  ALU control, widths as packed above
//  ex_valid      out  1   EX holds a real instruction
//  ex_wr_reg     out  RW  latched destination
//  ex_wr_en      out  1   latched write enable, forced 0 when ex_valid=0
//  ex_halted     out  1   HALT has reached EX; pipeline frozen
// BEHAVIOUR
//  - Reset (rst_n=0, async): all latched fields 0, ex_valid=0, ex_wr_en=0, FSM=RUN, ex_halted=0; A=B=0 if no forward match.
//  - FSM RUN: each edge, priority flush > stall > load.
//      flush: ex_valid, ex_wr_en, halt bit <= 0; operands/control <= 0.
//      stall: all latches hold.
//      load: latch all id_* fields; ex_valid<=id_valid; ex_wr_en<=id_wr_en&id_valid.
//      A loaded valid id_halt (no flush, no stall) moves FSM to HALTED on that edge.
//  - FSM HALTED: ex_halted=1; stall, flush and id_* ignored; all latches frozen; exit only via reset.
//  - Latency: 1 cycle ID->EX registers; forwarding is combinational from latched rs/rt to A/B (same cycle).
//  - Forwarding for A (B identical with rt/rt_used):
//      rs_used & ex_valid & exm_wr_en & exm_wr_reg==rs -> exm_data   (highest priority)
//      else rs_used & ex_valid & mwb_wr_en & mwb_wr_reg==rs -> mwb_data
//      else latched id_A.
//  - Both producers matching: EX/MEM wins (youngest value). rs==rt with both used: both operands forwarded.
//  - ex_valid=0: no forwarding; A/B show latched values (0 after flush).
//  - Width rule: no arithmetic here; all data paths exactly DW bits, no extension.
// CONFIGURATION
//  ID_EX_FWD_EN defined: forwarding mux present as above.
//  ID_EX_FWD_EN undefined: A=latched id_A, B=latched id_B; exm_*/mwb_* inputs unused; the hazard unit must stall on all RAW hazards.
// TESTING
//  1 Reset mid-run: load A=16'h1234, then drop rst_n asynchronously -> outputs 0 immediately, ex_valid=0, FSM RUN.
//  2 Load/stall: load id_A=16'hBEEF, Op=3'b101; stall 3 cycles with new id_* -> A=16'hBEEF, Op=5 held all 3 cycles.
//  3 Flush+stall same edge: ex_valid=1 before; flush=1, stall=1 -> next cycle ex_valid=0, ex_wr_en=0, A=0.
//  4 Forward priority (FWD_EN): rs=3, id_A=16'h0001, exm{1,3,16'hAAAA}, mwb{1,3,16'h5555} -> A=16'hAAAA; drop exm_wr_en -> A=16'h5555; rs_used=0 -> A=16'h0001.
//  5 HALT: load valid id_halt -> next edge ex_halted=1; subsequent flush/new id_A=16'hFFFF -> all outputs unchanged until rst_n.
//  6 No-forward build (macro undefined): repeat test 4 -> A=16'h0001 in every case.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand bypass ahead of the ALU.
// Define ID_EX_FWD_EN to build the forwarding mux; otherwise A/B are the latched operands.
module id_ex_operand_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_A,
  input  logic [DW-1:0] id_B,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic [12:0]   id_alu_ctrl,
  input  logic [RW-1:0] id_wr_reg,
  input  logic          id_wr_en,
  input  logic          id_halt,
  input  logic          exm_wr_en,
  input  logic [RW-1:0] exm_wr_reg,
  input  logic [DW-1:0] exm_data,
  input  logic          mwb_wr_en,
  input  logic [RW-1:0] mwb_wr_reg,
  input  logic [DW-1:0] mwb_data,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic          Cin,
  output logic [2:0]    Op,
  output logic          invA,
  output logic          invB,
  output logic          sign,
  output logic          ex_BTR,
  output logic          ex_SLBI,
  output logic [1:0]    comp_cont,
  output logic          comp,
  output logic          pass,
  output logic          ex_valid,
  output logic [RW-1:0] ex_wr_reg,
  output logic          ex_wr_en,
  output logic          ex_halted
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [RW-1:0] rs_q, rs_d, rt_q, rt_d;
  logic          rs_used_q, rs_used_d, rt_used_q, rt_used_d;
  logic [12:0]   ctrl_q, ctrl_d;
  logic [RW-1:0] wr_reg_q, wr_reg_d;
  logic          wr_en_q, wr_en_d;
  logic [DW-1:0] a_fwd_s, b_fwd_s;

  // Next-state: flush beats stall beats load; HALTED freezes everything until reset.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    a_d       = a_q;
    b_d       = b_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rs_used_d = rs_used_q;
    rt_used_d = rt_used_q;
    ctrl_d    = ctrl_q;
    wr_reg_d  = wr_reg_q;
    wr_en_d   = wr_en_q;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          valid_d   = 1'b0;
          a_d       = '0;
          b_d       = '0;
          rs_d      = '0;
          rt_d      = '0;
          rs_used_d = 1'b0;
          rt_used_d = 1'b0;
          ctrl_d    = 13'd0;
          wr_reg_d  = '0;
          wr_en_d   = 1'b0;
          state_d   = ST_RUN;
        end else if (!stall) begin
          valid_d   = id_valid;
          a_d       = id_A;
          b_d       = id_B;
          rs_d      = id_rs;
          rt_d      = id_rt;
          rs_used_d = id_rs_used;
          rt_used_d = id_rt_used;
          ctrl_d    = id_alu_ctrl;
          wr_reg_d  = id_wr_reg;
          wr_en_d   = id_wr_en & id_valid;
          state_d   = (id_valid && id_halt) ? ST_HALTED : ST_RUN;
        end else begin
          state_d   = ST_RUN;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Pipeline register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rs_used_q <= 1'b0;
      rt_used_q <= 1'b0;
      ctrl_q    <= 13'd0;
      wr_reg_q  <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rs_used_q <= rs_used_d;
      rt_used_q <= rt_used_d;
      ctrl_q    <= ctrl_d;
      wr_reg_q  <= wr_reg_d;
      wr_en_q   <= wr_en_d;
    end
  end

`ifdef ID_EX_FWD_EN
  // Bypass mux: EX/MEM holds the youngest value, so it outranks MEM/WB.
  always_comb begin
    a_fwd_s = a_q;
    b_fwd_s = b_q;
    if (rs_used_q && valid_q && exm_wr_en && (exm_wr_reg == rs_q)) begin
      a_fwd_s = exm_data;
    end else if (rs_used_q && valid_q && mwb_wr_en && (mwb_wr_reg == rs_q)) begin
      a_fwd_s = mwb_data;
    end else begin
      a_fwd_s = a_q;
    end
    if (rt_used_q && valid_q && exm_wr_en && (exm_wr_reg == rt_q)) begin
      b_fwd_s = exm_data;
    end else if (rt_used_q && valid_q && mwb_wr_en && (mwb_wr_reg == rt_q)) begin
      b_fwd_s = mwb_data;
    end else begin
      b_fwd_s = b_q;
    end
  end
`else
  // Without bypass the hazard unit stalls on every RAW hazard; producer ports are ignored.
  logic unused_fwd_s;
  assign unused_fwd_s = ^{exm_wr_en, exm_wr_reg, exm_data, mwb_wr_en, mwb_wr_reg, mwb_data,
                          rs_q, rt_q, rs_used_q, rt_used_q};
  assign a_fwd_s = a_q;
  assign b_fwd_s = b_q;
`endif

  assign A         = a_fwd_s;
  assign B         = b_fwd_s;
  assign Cin       = ctrl_q[12];
  assign Op        = ctrl_q[11:9];
  assign invA      = ctrl_q[8];
  assign invB      = ctrl_q[7];
  assign sign      = ctrl_q[6];
  assign ex_BTR    = ctrl_q[5];
  assign ex_SLBI   = ctrl_q[4];
  assign comp_cont = ctrl_q[3:2];
  assign comp      = ctrl_q[1];
  assign pass      = ctrl_q[0];
  assign ex_valid  = valid_q;
  assign ex_wr_reg = wr_reg_q;
  assign ex_wr_en  = wr_en_q & valid_q;
  assign ex_halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: driver pushes model predictions, monitor pops and compares.
module tb_id_ex_operand_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic        clk, rst_n, stall, flush, id_valid, id_rs_used, id_rt_used, id_wr_en, id_halt;
  logic [15:0] id_A, id_B, exm_data, mwb_data;
  logic [2:0]  id_rs, id_rt, id_wr_reg, exm_wr_reg, mwb_wr_reg;
  logic [12:0] id_alu_ctrl;
  logic        exm_wr_en, mwb_wr_en;
  logic [15:0] A, B;
  logic        Cin, invA, invB, sign, ex_BTR, ex_SLBI, comp, pass;
  logic [2:0]  Op, ex_wr_reg;
  logic [1:0]  comp_cont;
  logic        ex_valid, ex_wr_en, ex_halted;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_A(id_A), .id_B(id_B), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_alu_ctrl(id_alu_ctrl),
    .id_wr_reg(id_wr_reg), .id_wr_en(id_wr_en), .id_halt(id_halt),
    .exm_wr_en(exm_wr_en), .exm_wr_reg(exm_wr_reg), .exm_data(exm_data),
    .mwb_wr_en(mwb_wr_en), .mwb_wr_reg(mwb_wr_reg), .mwb_data(mwb_data),
    .A(A), .B(B), .Cin(Cin), .Op(Op), .invA(invA), .invB(invB), .sign(sign),
    .ex_BTR(ex_BTR), .ex_SLBI(ex_SLBI), .comp_cont(comp_cont), .comp(comp), .pass(pass),
    .ex_valid(ex_valid), .ex_wr_reg(ex_wr_reg), .ex_wr_en(ex_wr_en), .ex_halted(ex_halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the instruction currently sitting in EX, as a plain record.
  typedef struct packed {
    logic        valid;
    logic [15:0] a, b;
    logic [2:0]  rs, rt;
    logic        rs_used, rt_used;
    logic [12:0] ctrl;
    logic [2:0]  wr_reg;
    logic        wr_en;
    logic        halted;
  } ex_t;

  ex_t         m;
  logic [50:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  wire [50:0] dut_vec = {A, B, Cin, Op, invA, invB, sign, ex_BTR, ex_SLBI, comp_cont, comp, pass,
                         ex_valid, ex_wr_reg, ex_wr_en, ex_halted};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] fwd(input logic used, input logic [2:0] r, input logic [15:0] lat);
    if (FWD_EN && used && m.valid && exm_wr_en && exm_wr_reg == r) return exm_data;
    if (FWD_EN && used && m.valid && mwb_wr_en && mwb_wr_reg == r) return mwb_data;
    return lat;
  endfunction

  function automatic logic [50:0] expect_vec();
    return {fwd(m.rs_used, m.rs, m.a), fwd(m.rt_used, m.rt, m.b), m.ctrl,
            m.valid, m.wr_reg, m.wr_en & m.valid, m.halted};
  endfunction

  task automatic model_edge();
    if (m.halted) begin
      m = m;
    end else if (flush) begin
      m = '0;
    end else if (!stall) begin
      m.valid   = id_valid;
      m.a       = id_A;
      m.b       = id_B;
      m.rs      = id_rs;
      m.rt      = id_rt;
      m.rs_used = id_rs_used;
      m.rt_used = id_rt_used;
      m.ctrl    = id_alu_ctrl;
      m.wr_reg  = id_wr_reg;
      m.wr_en   = id_wr_en & id_valid;
      m.halted  = id_valid & id_halt;
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    model_edge();
    exp_q.push_back(expect_vec());
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall = 1'b0; flush = 1'b0; id_valid = 1'b0; id_A = 16'h0000; id_B = 16'h0000;
    id_rs = 3'd0; id_rt = 3'd0; id_rs_used = 1'b0; id_rt_used = 1'b0; id_alu_ctrl = 13'd0;
    id_wr_reg = 3'd0; id_wr_en = 1'b0; id_halt = 1'b0;
    exm_wr_en = 1'b0; exm_wr_reg = 3'd0; exm_data = 16'h0000;
    mwb_wr_en = 1'b0; mwb_wr_reg = 3'd0; mwb_data = 16'h0000;
  endtask

  task automatic rnd_inputs();
    stall       = ($urandom_range(0, 3) == 0);
    flush       = ($urandom_range(0, 7) == 0);
    id_valid    = ($urandom_range(0, 4) != 0);
    id_A        = 16'($urandom);
    id_B        = 16'($urandom);
    id_rs       = 3'($urandom);
    id_rt       = ($urandom_range(0, 3) == 0) ? id_rs : 3'($urandom);
    id_rs_used  = 1'($urandom);
    id_rt_used  = 1'($urandom);
    id_alu_ctrl = 13'($urandom);
    id_wr_reg   = 3'($urandom);
    id_wr_en    = 1'($urandom);
    id_halt     = ($urandom_range(0, 40) == 0);
    exm_wr_en   = 1'($urandom);
    exm_wr_reg  = ($urandom_range(0, 1) == 0) ? m.rs : 3'($urandom);
    exm_data    = 16'($urandom);
    mwb_wr_en   = 1'($urandom);
    mwb_wr_reg  = ($urandom_range(0, 1) == 0) ? m.rt : 3'($urandom);
    mwb_data    = 16'($urandom);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic reset_pulse();
    rst_n = 1'b0;
    m = '0;
    #1;
    exm_wr_en = 1'b0;
    mwb_wr_en = 1'b0;
    #1;
    chk("async_reset_vec", 64'(dut_vec), 64'(expect_vec()));
    chk("async_reset_valid", 64'(ex_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every output sample just after a rising edge is matched with its prediction.
  initial begin
    logic [50:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("scoreboard", 64'(dut_vec), 64'(e));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    m = '0;
    clear_inputs();
    @(negedge clk);
    chk("reset_state", 64'(dut_vec), 64'd0);
    rst_n = 1'b1;

    // Load then asynchronous reset mid-run
    id_valid = 1'b1; id_A = 16'h1234;
    step();
    chk("load_A", 64'(A), 64'h1234);
    reset_pulse();
    chk("after_reset_A", 64'(A), 64'h0000);

    // Load then hold across three stalled cycles with fresh decode data
    clear_inputs();
    id_valid = 1'b1; id_A = 16'hBEEF; id_alu_ctrl = 13'b0_101_0000_00000;
    step();
    for (int i = 0; i < 3; i++) begin
      rnd_inputs();
      stall = 1'b1; flush = 1'b0;
      step();
      chk("stall_A", 64'(A), 64'hBEEF);
      chk("stall_Op", 64'(Op), 64'd5);
    end

    // Flush and stall on the same edge: flush wins
    clear_inputs();
    id_valid = 1'b1; id_A = 16'h7777; id_wr_en = 1'b1; id_wr_reg = 3'd6;
    step();
    chk("pre_flush_valid", 64'(ex_valid), 64'd1);
    flush = 1'b1; stall = 1'b1;
    step();
    chk("flush_valid", 64'(ex_valid), 64'd0);
    chk("flush_wr_en", 64'(ex_wr_en), 64'd0);
    chk("flush_A", 64'(A), 64'h0000);

    // Forwarding priority on operand A
    clear_inputs();
    id_valid = 1'b1; id_rs = 3'd3; id_rs_used = 1'b1; id_A = 16'h0001;
    exm_wr_en = 1'b1; exm_wr_reg = 3'd3; exm_data = 16'hAAAA;
    mwb_wr_en = 1'b1; mwb_wr_reg = 3'd3; mwb_data = 16'h5555;
    step();
    chk("fwd_exm", 64'(A), FWD_EN ? 64'hAAAA : 64'h0001);
    stall = 1'b1; exm_wr_en = 1'b0;
    step();
    chk("fwd_mwb", 64'(A), FWD_EN ? 64'h5555 : 64'h0001);
    stall = 1'b0; id_rs_used = 1'b0;
    step();
    chk("fwd_unused", 64'(A), 64'h0001);

    // Same register on both sources: both operands bypassed
    clear_inputs();
    id_valid = 1'b1; id_rs = 3'd0; id_rt = 3'd0; id_rs_used = 1'b1; id_rt_used = 1'b1;
    id_A = 16'h1111; id_B = 16'h2222;
    mwb_wr_en = 1'b1; mwb_wr_reg = 3'd0; mwb_data = 16'hC0DE;
    step();
    chk("fwd_both_B", 64'(B), FWD_EN ? 64'hC0DE : 64'h2222);

    // HALT reaches EX and freezes the stage
    clear_inputs();
    id_valid = 1'b1; id_halt = 1'b1; id_A = 16'h4242;
    step();
    chk("halt_set", 64'(ex_halted), 64'd1);
    for (int i = 0; i < 4; i++) begin
      rnd_inputs();
      id_A = 16'hFFFF; flush = 1'b1; exm_wr_en = 1'b0; mwb_wr_en = 1'b0;
      step();
      chk("halt_hold_A", 64'(A), 64'h4242);
      chk("halt_hold_flag", 64'(ex_halted), 64'd1);
    end
    reset_pulse();

    // Randomized traffic; reset occasionally to escape HALT
    for (int i = 0; i < 600; i++) begin
      if (m.halted && $urandom_range(0, 5) == 0) begin
        reset_pulse();
      end else begin
        rnd_inputs();
        step();
      end
    end

    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
